// File: rtl/bram_responder_pkg.sv
// Shared types and defaults for the BRAM responder: FSM state encoding and
// the default memory depth and watchdog limit.
package bram_responder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_RUN   = 4'd2,
        ST_ERR   = 4'd3
    } state_e;

    localparam int DEF_ADDR_W  = 13;
    localparam int DEF_TIMEOUT = 65535;

endpackage

// File: rtl/bram_responder_if.sv
// Bus bundle for the responder: the PE-facing BRAM port (A) and the host
// request/response port (B).
interface bram_responder_if
    import bram_responder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [31:0]       BRAM_ADDR;
    logic [31:0]       BRAM_WRDATA;
    logic [3:0]        BRAM_WE;
    logic [31:0]       BRAM_RDDATA;

    logic              host_valid;
    logic              host_ready;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [31:0]       host_wdata;

    logic              host_rvalid;
    logic              host_rready;
    logic [31:0]       host_rdata;

    modport slave (
        input  BRAM_ADDR, BRAM_WRDATA, BRAM_WE,
        output BRAM_RDDATA,
        input  host_valid, host_we, host_addr, host_wdata, host_rready,
        output host_ready, host_rvalid, host_rdata
    );

    modport master (
        output BRAM_ADDR, BRAM_WRDATA, BRAM_WE,
        input  BRAM_RDDATA,
        output host_valid, host_we, host_addr, host_wdata, host_rready,
        input  host_ready, host_rvalid, host_rdata
    );
endinterface

// File: rtl/bram_responder_mem.sv
// Dual-port read-first word memory. Port A has byte enables and wins over
// port B on the bytes it writes when both hit the same word.
module bram_dp_mem #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [3:0]        a_we,
    input  logic [31:0]       a_wdata,
    output logic [31:0]       a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_we,
    input  logic              b_re,
    input  logic [31:0]       b_wdata,
    output logic [31:0]       b_rdata
);
    logic [31:0] mem [2**ADDR_W];
    logic [31:0] a_rdata_q, a_rdata_d;
    logic [31:0] b_rdata_q, b_rdata_d;

    always_comb begin
        a_rdata_d = mem[a_addr];
        b_rdata_d = b_rdata_q;
        if (b_re) begin
            b_rdata_d = mem[b_addr];
        end
    end

    // Port B first so that port A's byte lanes take priority on a collision.
    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
        for (int k = 0; k < 4; k++) begin
            if (a_we[k]) begin
                mem[a_addr][8*k +: 8] <= a_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
endmodule

// File: rtl/bram_responder.sv
// BRAM responder: shared matrix memory between the host and the PE array,
// plus the run sequencer (kick/start/done) with watchdog and write counter.
//
//  state | meaning
//  IDLE  | host owns the memory, waiting for kick
//  START | one-cycle start pulse to the PE controller, counters cleared
//  RUN   | PE array owns the memory, watchdog running, waiting for done
//  ERR   | watchdog expired, host port open, waiting for err_clr
module bram_responder
    import bram_responder_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   aclk,
    input  logic                   areset,
    bram_responder_if.slave        bus,
    input  logic                   kick,
    output logic                   start,
    input  logic                   done,
    output logic                   busy,
    output logic                   done_irq,
    output logic                   err,
    input  logic                   err_clr,
    output logic [15:0]            wr_cnt
);
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_irq_q, done_irq_d;
    logic              err_q, err_d;
    logic              err_stk_q, err_stk_d;
    logic              rvalid_q, rvalid_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;

    logic              host_rdy;
    logic              host_wr;
    logic              host_rd;
    logic              a_wr;
    logic [ADDR_W-1:0] a_idx;
    logic [31:0]       a_rdata;
    logic [31:0]       b_rdata;
    logic              unused_addr_bits;

    // Byte offset and bits above the depth are dropped, so addresses wrap.
    assign a_idx            = bus.BRAM_ADDR[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.BRAM_ADDR[31:ADDR_W+2], bus.BRAM_ADDR[1:0]};
    assign a_wr             = |bus.BRAM_WE;

    assign host_rdy = ((state_q == ST_IDLE) || (state_q == ST_ERR)) &&
                      !(rvalid_q && !bus.host_rready);
    assign host_wr  = bus.host_valid && host_rdy && bus.host_we;
    assign host_rd  = bus.host_valid && host_rdy && !bus.host_we;

    bram_dp_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk     (aclk),
        .rst     (areset),
        .a_addr  (a_idx),
        .a_we    (bus.BRAM_WE),
        .a_wdata (bus.BRAM_WRDATA),
        .a_rdata (a_rdata),
        .b_addr  (bus.host_addr),
        .b_we    (host_wr),
        .b_re    (host_rd),
        .b_wdata (bus.host_wdata),
        .b_rdata (b_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wdog_d     = wdog_q;
        wr_cnt_d   = wr_cnt_q;
        done_irq_d = 1'b0;
        err_stk_d  = err_stk_q;
        rvalid_d   = rvalid_q;

        case (state_q)
            ST_IDLE: begin
                if (kick) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                wr_cnt_d = '0;
                wdog_d   = '0;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                wdog_d = wdog_q + WD_W'(1);
                if (a_wr && (wr_cnt_q != 16'hFFFF)) begin
                    wr_cnt_d = wr_cnt_q + 16'd1;
                end
                // done wins over a coincident kick or watchdog expiry
                if (done) begin
                    state_d    = ST_IDLE;
                    done_irq_d = 1'b1;
                end else if (wdog_d == WD_W'(TIMEOUT)) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (err_clr) begin
            err_stk_d = 1'b0;
        end
        if (a_wr && (state_q != ST_RUN)) begin
            err_stk_d = 1'b1;
        end

        if (host_rd) begin
            rvalid_d = 1'b1;
        end else if (bus.host_rready) begin
            rvalid_d = 1'b0;
        end

        start_d = (state_d == ST_START);
        busy_d  = (state_d == ST_START) || (state_d == ST_RUN);
        err_d   = (state_d == ST_ERR) || err_stk_d;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_irq_q <= 1'b0;
            err_q      <= 1'b0;
            err_stk_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            wr_cnt_q   <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_irq_q <= done_irq_d;
            err_q      <= err_d;
            err_stk_q  <= err_stk_d;
            rvalid_q   <= rvalid_d;
            wr_cnt_q   <= wr_cnt_d;
            wdog_q     <= wdog_d;
        end
    end

    assign start            = start_q;
    assign busy             = busy_q;
    assign done_irq         = done_irq_q;
    assign err              = err_q;
    assign wr_cnt           = wr_cnt_q;
    assign bus.host_ready   = host_rdy;
    assign bus.host_rvalid  = rvalid_q;
    assign bus.host_rdata   = b_rdata;
    assign bus.BRAM_RDDATA  = a_rdata;
endmodule

// File: doc/bram_responder.md
BRAM_RESPONDER -- requirements
Module: bram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, giving log2 of the word depth (8192 x 32-bit words; holds a 64x64 matrix, a vector and results).
REQ-002 SHALL have parameter TIMEOUT, default 65535, giving the maximum number of RUN-state cycles before a watchdog error.
REQ-003 SHALL use one clock and synchronous active-high reset; port aclk, input, 1 bit, the single clock, all logic on its rising edge.
REQ-004 SHALL have port areset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have BRAM-side ports: BRAM_ADDR in 32 (byte address); BRAM_WRDATA in 32; BRAM_WE in 4 (per-byte write enables); BRAM_RDDATA out 32.
REQ-006 SHALL have host request ports: host_valid in 1; host_ready out 1; host_we in 1; host_addr in ADDR_W (word address); host_wdata in 32.
REQ-007 SHALL have host response ports: host_rvalid out 1; host_rready in 1; host_rdata out 32.
REQ-008 SHALL have sequencing ports: kick in 1 (run request); start out 1 (to the PE controller); done in 1 (from the PE controller); busy out 1; done_irq out 1; err out 1; err_clr in 1; wr_cnt out 16 (count of BRAM word writes in the current run).

Function
REQ-009 SHALL contain one dual-port word memory of 2^ADDR_W x 32 bits: port A serves BRAM_*, port B serves host_*.
REQ-010 SHALL form the port-A word index from BRAM_ADDR[ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 are ignored, so out-of-range addresses wrap.
REQ-011 SHALL serve port A every cycle with no stall: BRAM_RDDATA is registered and presents mem[index] one cycle after the address; a write on the same cycle as a read returns the old data (read-first).
REQ-012 SHALL make BRAM_WE[k] write byte k (bits 8k+7:8k) of BRAM_WRDATA; BRAM_WE=0 is a pure read.
REQ-013 SHALL implement a sequencing FSM with states IDLE, START, RUN and ERR; it is IDLE after reset.
REQ-014 IDLE: host port enabled, busy=0; kick=1 goes to START.
REQ-015 START: lasts exactly 1 cycle with start=1 and busy=1, clears wr_cnt and the watchdog counter, then goes to RUN.
REQ-016 RUN: busy=1, host_ready=0, watchdog increments each cycle; done=1 returns to IDLE with done_irq=1 for exactly 1 cycle; if the watchdog reaches TIMEOUT, goes to ERR.
REQ-017 ERR: busy=0, err=1, host port enabled; err_clr=1 returns to IDLE; kick is ignored while in ERR.
REQ-018 In any state other than RUN, a BRAM write (BRAM_WE!=0) SHALL still be performed and SHALL set err sticky; err then clears only via err_clr or reset, and the FSM state is unchanged.
REQ-019 SHALL increment wr_cnt on each cycle in RUN with BRAM_WE!=0; wr_cnt saturates at 16'hFFFF and holds its value after the run.
REQ-020 SHALL drive host_ready = (state is IDLE or ERR) AND NOT (host_rvalid AND NOT host_rready).
REQ-021 Host write: on host_valid and host_ready with host_we=1, write the full word host_wdata to mem[host_addr] at that edge; no response is produced.
REQ-022 Host read: on host_valid and host_ready with host_we=0, assert host_rvalid the next cycle with mem[host_addr]; host_rvalid and host_rdata hold until host_rready=1.
REQ-023 When host_rready=1 and a new read is accepted in the same cycle, host_rvalid SHALL stay 1 with the new data (back-to-back, 1 read per cycle).
REQ-024 Simultaneous writes to the same word from both ports SHALL resolve with port A winning; host_rdata for a same-cycle, same-address read is the pre-write data.
REQ-025 kick and done arriving in the same cycle while in RUN: done is taken, the FSM goes to IDLE, and kick is dropped.
REQ-026 done outside RUN SHALL be ignored.

Reset
REQ-027 On areset=1 at a clock edge: FSM is IDLE; start, busy, done_irq, err, host_rvalid are 0; BRAM_RDDATA and host_rdata are 0; wr_cnt and the watchdog are 0.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset in RUN SHALL abort the run with no done_irq.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (4-bit, IDLE=0, START=1, RUN=2, ERR=3) and the default ADDR_W and TIMEOUT constants.
REQ-031 The memory SHALL be one sub-module, bram_dp_mem: two synchronous read-first ports, port A with byte enables, port B word-wide, inferred as block RAM.

Verification
REQ-032 Host writes 0x11223344 to word 5, then reads word 5 -> host_rvalid one cycle later with 0x11223344.
REQ-033 Host writes 0xAABBCCDD to word 0; BRAM_ADDR=0x0, BRAM_WE=4'b0101, BRAM_WRDATA=0x00110022; next cycle BRAM_ADDR=0x0 read -> BRAM_RDDATA=0xAA11CC22 one cycle later.
REQ-034 kick=1 -> start=1 for one cycle, then busy=1 and host_ready=0; 64 BRAM writes, then done=1 -> done_irq pulse, wr_cnt=64, host_ready=1.
REQ-035 TIMEOUT=100, kick with done never asserted -> err=1 after 100 RUN cycles; err_clr=1 -> IDLE, err=0.
REQ-036 Host read with host_rready=0 for 3 cycles -> host_rdata stable, host_ready=0; host_rready=1 -> host_ready=1 next cycle.
REQ-037 BRAM_ADDR=0x0000_8004 (beyond depth) read -> returns word 1; BRAM write while in IDLE -> err=1.
